vga_timing_gen: RTL

//  Raster timing generator for the VGA output path. Sits directly upstream of every sprite/background

---
 rtl/vga_timing_gen.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel/line counters, sync pulses, visible-area flag and
// per-frame/per-line strobes, all registered and mutually aligned to (DrawX, DrawY).
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int FRAME_W   = 8
) (
    input  logic               vga_clk,
    input  logic               reset_n,
    output logic [9:0]         DrawX,
    output logic [9:0]         DrawY,
    output logic               hs,
    output logic               vs,
    output logic               blank,
    output logic               line_start,
    output logic               frame_start,
    output logic               vblank_start,
    output logic [FRAME_W-1:0] frame_count
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_FP_START   = 10'(H_VISIBLE);
    localparam logic [9:0] H_SYNC_START = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] H_BP_START   = 10'(H_VISIBLE + H_FP + H_SYNC);

    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_FP_START   = 10'(V_VISIBLE);
    localparam logic [9:0] V_SYNC_START = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] V_BP_START   = 10'(V_VISIBLE + V_FP + V_SYNC);

    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FRONT  = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BACK   = 2'd3
    } phase_t;

    logic [9:0]         r_x;
    logic [9:0]         r_y;
    logic [FRAME_W-1:0] r_frame_count;
    phase_t             r_h_phase;
    phase_t             r_v_phase;
    logic               r_hs;
    logic               r_vs;
    logic               r_blank;
    logic               r_line_start;
    logic               r_frame_start;
    logic               r_vblank_start;

    logic               w_h_wrap;
    logic               w_v_wrap;
    logic [9:0]         w_x_nxt;
    logic [9:0]         w_y_nxt;
    logic [FRAME_W-1:0] w_fc_nxt;
    phase_t             w_h_phase_nxt;
    phase_t             w_v_phase_nxt;
    logic               w_hs_nxt;
    logic               w_vs_nxt;
    logic               w_blank_nxt;
    logic               w_line_start_nxt;
    logic               w_frame_start_nxt;
    logic               w_vblank_start_nxt;

    assign w_h_wrap = (r_x == H_LAST);
    assign w_v_wrap = w_h_wrap && (r_y == V_LAST);

    // Next pixel position and completed-frame count.
    always_comb begin
        w_x_nxt  = r_x + 10'd1;
        w_y_nxt  = r_y;
        w_fc_nxt = r_frame_count;
        if (w_h_wrap) begin
            w_x_nxt = 10'd0;
            if (w_v_wrap) begin
                w_y_nxt  = 10'd0;
                w_fc_nxt = r_frame_count + FRAME_W'(1'b1);
            end else begin
                w_y_nxt  = r_y + 10'd1;
                w_fc_nxt = r_frame_count;
            end
        end else begin
            w_y_nxt = r_y;
        end
    end

    // Horizontal phase next-state; any line wrap forces ACTIVE, which also recovers a corrupt phase.
    always_comb begin
        w_h_phase_nxt = r_h_phase;
        if (w_h_wrap) begin
            w_h_phase_nxt = PH_ACTIVE;
        end else begin
            case (r_h_phase)
                PH_ACTIVE: if (w_x_nxt == H_FP_START)   w_h_phase_nxt = PH_FRONT; else w_h_phase_nxt = PH_ACTIVE;
                PH_FRONT:  if (w_x_nxt == H_SYNC_START) w_h_phase_nxt = PH_SYNC;  else w_h_phase_nxt = PH_FRONT;
                PH_SYNC:   if (w_x_nxt == H_BP_START)   w_h_phase_nxt = PH_BACK;  else w_h_phase_nxt = PH_SYNC;
                PH_BACK:   w_h_phase_nxt = PH_BACK;
                default:   w_h_phase_nxt = PH_ACTIVE;
            endcase
        end
    end

    // Vertical phase next-state; advances only when the line wraps.
    always_comb begin
        w_v_phase_nxt = r_v_phase;
        if (!w_h_wrap) begin
            w_v_phase_nxt = r_v_phase;
        end else if (w_v_wrap) begin
            w_v_phase_nxt = PH_ACTIVE;
        end else begin
            case (r_v_phase)
                PH_ACTIVE: if (w_y_nxt == V_FP_START)   w_v_phase_nxt = PH_FRONT; else w_v_phase_nxt = PH_ACTIVE;
                PH_FRONT:  if (w_y_nxt == V_SYNC_START) w_v_phase_nxt = PH_SYNC;  else w_v_phase_nxt = PH_FRONT;
                PH_SYNC:   if (w_y_nxt == V_BP_START)   w_v_phase_nxt = PH_BACK;  else w_v_phase_nxt = PH_SYNC;
                PH_BACK:   w_v_phase_nxt = PH_BACK;
                default:   w_v_phase_nxt = PH_ACTIVE;
            endcase
        end
    end

    // Output decode from next-state values so registered outputs line up with the new position.
    always_comb begin
        w_hs_nxt           = (w_h_phase_nxt != PH_SYNC);
        w_vs_nxt           = (w_v_phase_nxt != PH_SYNC);
        w_blank_nxt        = (w_h_phase_nxt == PH_ACTIVE) && (w_v_phase_nxt == PH_ACTIVE);
        w_line_start_nxt   = (w_x_nxt == 10'd0) && (w_v_phase_nxt == PH_ACTIVE);
        w_frame_start_nxt  = (w_x_nxt == 10'd0) && (w_y_nxt == 10'd0);
        w_vblank_start_nxt = (w_x_nxt == 10'd0) && (w_y_nxt == V_FP_START);
    end

    // Counter and phase state registers.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_x           <= 10'd0;
            r_y           <= 10'd0;
            r_frame_count <= '0;
            r_h_phase     <= PH_ACTIVE;
            r_v_phase     <= PH_ACTIVE;
        end else begin
            r_x           <= w_x_nxt;
            r_y           <= w_y_nxt;
            r_frame_count <= w_fc_nxt;
            r_h_phase     <= w_h_phase_nxt;
            r_v_phase     <= w_v_phase_nxt;
        end
    end

    // Registered sync, visible flag and strobes; pulses stay low while in reset.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hs           <= 1'b1;
            r_vs           <= 1'b1;
            r_blank        <= 1'b0;
            r_line_start   <= 1'b0;
            r_frame_start  <= 1'b0;
            r_vblank_start <= 1'b0;
        end else begin
            r_hs           <= w_hs_nxt;
            r_vs           <= w_vs_nxt;
            r_blank        <= w_blank_nxt;
            r_line_start   <= w_line_start_nxt;
            r_frame_start  <= w_frame_start_nxt;
            r_vblank_start <= w_vblank_start_nxt;
        end
    end

    assign DrawX        = r_x;
    assign DrawY        = r_y;
    assign hs           = r_hs;
    assign vs           = r_vs;
    assign blank        = r_blank;
    assign line_start   = r_line_start;
    assign frame_start  = r_frame_start;
    assign vblank_start = r_vblank_start;
    assign frame_count  = r_frame_count;

endmodule
